// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types and constants for the UART byte-to-command bridge.
package uart_cmd_assembler_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 16;
    localparam int unsigned OP_W   = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    // Assembled command payload, high byte received first.
    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } cmd_t;

    localparam logic [BYTE_W-1:0] RESP_ACK = 8'hA5;
    localparam logic [OP_W-1:0]   OP_CAL   = 4'h2;
    localparam logic [OP_W-1:0]   OP_MOVE  = 4'h4;

    // Opcode lives in the top nibble of the command.
    function automatic logic [OP_W-1:0] cmd_opcode(input cmd_t c);
        return c.hi[BYTE_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/uart_cmd_assembler_resp_tx_queue.sv
// Response transmit path: TX FSM plus a one-deep pending buffer.
module uart_cmd_assembler_resp_tx_queue
    import uart_cmd_assembler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] resp,
    input  logic              send_resp,
    input  logic              tx_done,
    output logic [BYTE_W-1:0] tx_data,
    output logic              trmt,
    output logic              resp_busy,
    output logic              resp_drop
);

    tx_state_t         state_q, state_d;
    logic [BYTE_W-1:0] pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              trmt_q, trmt_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state: launch, queue or drop responses; drain the pending slot on tx_done.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        tx_data_d = tx_data_q;
        trmt_d    = 1'b0;
        drop_d    = drop_q;
        case (state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d = resp;
                    trmt_d    = 1'b1;
                    state_d   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (send_resp && pend_v_q) begin
                    drop_d = 1'b1;
                end
                if (tx_done) begin
                    if (pend_v_q) begin
                        tx_data_d = pend_q;
                        trmt_d    = 1'b1;
                        pend_v_d  = 1'b0;
                    end else if (send_resp) begin
                        // Transmitter freed this cycle: send the new request directly.
                        tx_data_d = resp;
                        trmt_d    = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else if (send_resp && !pend_v_q) begin
                    pend_d   = resp;
                    pend_v_d = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        busy_d = (state_d == TX_BUSY) | pend_v_d;
    end

    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_busy = busy_q;
    assign resp_drop = drop_q;

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles two UART bytes into a 16-bit command and forwards response bytes to the transmitter.
module uart_cmd_assembler
    import uart_cmd_assembler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned TMR_W       = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic [BYTE_W-1:0] resp,
    input  logic              send_resp,
    output logic [BYTE_W-1:0] tx_data,
    output logic              trmt,
    input  logic              tx_done,
    output logic              resp_busy,
    output logic              overrun,
    output logic              resp_drop,
    output logic              timeout
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    rx_state_t         rx_state_q, rx_state_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    cmd_t              cmd_q, cmd_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic              clr_rx_q, clr_rx_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              rx_take;

    // A byte is taken only if we did not just clear it, so a slow rx_rdy drop is not re-read.
    assign rx_take = rx_rdy & ~clr_rx_q;

    // RX state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= IDLE;
            hi_q       <= '0;
            tmr_q      <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            clr_rx_q   <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            hi_q       <= hi_d;
            tmr_q      <= tmr_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            clr_rx_q   <= clr_rx_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state: capture high byte, then low byte or give up after the inter-byte timeout.
    always_comb begin
        rx_state_d = rx_state_q;
        hi_d       = hi_q;
        tmr_d      = tmr_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q & ~clr_cmd_rdy;
        clr_rx_d   = 1'b0;
        overrun_d  = overrun_q;
        timeout_d  = 1'b0;
        case (rx_state_q)
            IDLE: begin
                if (rx_take) begin
                    hi_d       = rx_data;
                    tmr_d      = '0;
                    clr_rx_d   = 1'b1;
                    rx_state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (rx_take) begin
                    // Completion wins over a same-cycle clear from the consumer.
                    cmd_d      = '{hi: hi_q, lo: rx_data};
                    cmd_rdy_d  = 1'b1;
                    overrun_d  = overrun_q | (cmd_rdy_q & ~clr_cmd_rdy);
                    clr_rx_d   = 1'b1;
                    rx_state_d = IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    timeout_d  = 1'b1;
                    rx_state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    assign clr_rx_rdy = clr_rx_q;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

    uart_cmd_assembler_resp_tx_queue u_tx (
        .clk       (clk),
        .rst       (rst),
        .resp      (resp),
        .send_resp (send_resp),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .resp_busy (resp_busy),
        .resp_drop (resp_drop)
    );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: vector table, directed corners, random vs. model.
module tb_uart_cmd_assembler;

    localparam int unsigned T = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_busy;
    logic        overrun;
    logic        resp_drop;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    uart_cmd_assembler #(.TIMEOUT_CYC(T), .TMR_W(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .resp_busy   (resp_busy),
        .overrun     (overrun),
        .resp_drop   (resp_drop),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rx;
        logic [7:0]  d;
        logic        cc;
        logic        s;
        logic [7:0]  r;
        logic        dn;
        logic        e_clr;
        logic        e_rdy;
        logic [15:0] e_cmd;
        logic        e_trmt;
        logic [7:0]  e_tx;
        logic        e_busy;
        logic        e_drop;
    } vec_t;

    function automatic vec_t mk(input logic rx, input logic [7:0] d, input logic cc,
                                input logic s, input logic [7:0] r, input logic dn,
                                input logic e_clr, input logic e_rdy, input logic [15:0] e_cmd,
                                input logic e_trmt, input logic [7:0] e_tx,
                                input logic e_busy, input logic e_drop);
        vec_t v;
        v.rx = rx; v.d = d; v.cc = cc; v.s = s; v.r = r; v.dn = dn;
        v.e_clr = e_clr; v.e_rdy = e_rdy; v.e_cmd = e_cmd; v.e_trmt = e_trmt;
        v.e_tx = e_tx; v.e_busy = e_busy; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic idle_inputs();
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        tx_done     = 1'b0;
    endtask

    // Present one byte like a UART receiver: hold rx_rdy until clr_rx_rdy is seen.
    task automatic send_byte(input logic [7:0] b);
        bit seen = 1'b0;
        rx_rdy  = 1'b1;
        rx_data = b;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (clr_rx_rdy) seen = 1'b1;
        end
        rx_rdy = 1'b0;
        check($sformatf("clr_rx_seen_%0h", b), 64'(seen), 64'd1);
    endtask

    task automatic release_cmd();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", 64'(cmd_rdy), 64'd0);
    endtask

    // Reference model state: what the registered outputs should show after each edge.
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int          m_wait;
    logic        m_clr, m_rdy, m_ovr, m_to, m_trmt, m_drop;
    logic [15:0] m_cmd;
    logic [7:0]  m_tx;

    task automatic model_reset();
        rxq.delete(); txq.delete();
        m_wait = 0; m_clr = 0; m_rdy = 0; m_ovr = 0; m_to = 0;
        m_trmt = 0; m_drop = 0; m_cmd = '0; m_tx = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit take, done_cmd;
        int pre;
        take     = rx_rdy && !m_clr;
        done_cmd = 1'b0;
        m_clr    = 1'b0;
        m_to     = 1'b0;
        m_trmt   = 1'b0;
        if (take) begin
            rxq.push_back(rx_data);
            m_clr = 1'b1;
            if (rxq.size() == 1) m_wait = 0;
        end
        if (rxq.size() == 2) begin
            m_cmd    = {rxq[0], rxq[1]};
            done_cmd = 1'b1;
            rxq.delete();
        end else if (rxq.size() == 1 && !take) begin
            if (m_wait == int'(T) - 1) begin
                m_to = 1'b1;
                rxq.delete();
            end else begin
                m_wait++;
            end
        end
        if (done_cmd) begin
            if (m_rdy && !clr_cmd_rdy) m_ovr = 1'b1;
            m_rdy = 1'b1;
        end else if (clr_cmd_rdy) begin
            m_rdy = 1'b0;
        end
        // txq holds the byte on the wire (front) plus at most one waiting byte.
        pre = txq.size();
        if (send_resp && pre == 2) m_drop = 1'b1;
        if (tx_done && pre > 0) begin
            void'(txq.pop_front());
            if (txq.size() > 0) begin
                m_tx   = txq[0];
                m_trmt = 1'b1;
            end
        end
        if (send_resp && pre != 2) begin
            if (txq.size() == 0) begin
                m_tx   = resp;
                m_trmt = 1'b1;
            end
            txq.push_back(resp);
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[17];
        int   to_cnt;
        bit   stray;
        int   clr_cnt;
        int   rate;

        vt[0]  = mk(1, 8'h20, 0, 0, 8'h00, 0,  1, 0, 16'h0000, 0, 8'h00, 0, 0);
        vt[1]  = mk(0, 8'h20, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 0, 8'h00, 0, 0);
        vt[2]  = mk(1, 8'h00, 0, 0, 8'h00, 0,  1, 1, 16'h2000, 0, 8'h00, 0, 0);
        vt[3]  = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 16'h2000, 0, 8'h00, 0, 0);
        vt[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 16'h2000, 0, 8'h00, 0, 0);
        vt[5]  = mk(0, 8'h00, 1, 0, 8'h00, 0,  0, 0, 16'h2000, 0, 8'h00, 0, 0);
        vt[6]  = mk(0, 8'h00, 0, 1, 8'hA5, 0,  0, 0, 16'h2000, 1, 8'hA5, 1, 0);
        vt[7]  = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 16'h2000, 0, 8'hA5, 1, 0);
        vt[8]  = mk(0, 8'h00, 0, 1, 8'h5A, 0,  0, 0, 16'h2000, 0, 8'hA5, 1, 0);
        vt[9]  = mk(0, 8'h00, 0, 1, 8'h33, 0,  0, 0, 16'h2000, 0, 8'hA5, 1, 1);
        vt[10] = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 16'h2000, 1, 8'h5A, 1, 1);
        vt[11] = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 16'h2000, 0, 8'h5A, 1, 1);
        vt[12] = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 16'h2000, 0, 8'h5A, 0, 1);
        vt[13] = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 16'h2000, 0, 8'h5A, 0, 1);
        vt[14] = mk(0, 8'h00, 0, 1, 8'h77, 0,  0, 0, 16'h2000, 1, 8'h77, 1, 1);
        vt[15] = mk(0, 8'h00, 0, 1, 8'h11, 1,  0, 0, 16'h2000, 1, 8'h11, 1, 1);
        vt[16] = mk(0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 16'h2000, 0, 8'h11, 0, 1);

        rst = 1'b1;
        rx_data = '0;
        resp = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, resp_busy, overrun, resp_drop, timeout},
              '0);
        rst = 1'b0;

        // Basic assembly and the response queue, one row per clock.
        for (int i = 0; i < 17; i++) begin
            rx_rdy = vt[i].rx; rx_data = vt[i].d; clr_cmd_rdy = vt[i].cc;
            send_resp = vt[i].s; resp = vt[i].r; tx_done = vt[i].dn;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {clr_rx_rdy, cmd_rdy, cmd, trmt, tx_data, resp_busy, resp_drop},
                  {vt[i].e_clr, vt[i].e_rdy, vt[i].e_cmd, vt[i].e_trmt, vt[i].e_tx,
                   vt[i].e_busy, vt[i].e_drop});
        end
        idle_inputs();
        check("no_overrun_yet", 64'(overrun), 64'd0);

        // Half command then silence: exactly one timeout pulse at the expiry edge.
        send_byte(8'h4B);
        to_cnt = 0;
        for (int i = 1; i <= int'(T) + 5; i++) begin
            @(negedge clk);
            if (timeout) begin
                to_cnt++;
                check("timeout_cycle", 64'(i), 64'(T));
            end
        end
        check("timeout_count", 64'(to_cnt), 64'd1);
        check("cmd_rdy_after_timeout", 64'(cmd_rdy), 64'd0);
        send_byte(8'h4B);
        send_byte(8'hF1);
        check("cmd_4bf1", {cmd_rdy, cmd}, {1'b1, 16'h4BF1});
        release_cmd();

        // Low byte landing on the very edge the timer expires is still accepted.
        send_byte(8'h3C);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h5D);
        check("edge_accept_cmd", {cmd_rdy, cmd}, {1'b1, 16'h3C5D});
        check("edge_no_timeout", 64'(timeout), 64'd0);
        release_cmd();
        check("overrun_still_clear", 64'(overrun), 64'd0);

        // Back-to-back commands without acknowledge: overwrite and sticky overrun.
        send_byte(8'h4B); send_byte(8'hF1);
        send_byte(8'h20); send_byte(8'h00);
        check("overrun_cmd", {cmd_rdy, cmd}, {1'b1, 16'h2000});
        check("overrun_set", 64'(overrun), 64'd1);
        send_byte(8'h12);
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        send_byte(8'h34);
        clr_cmd_rdy = 1'b0;
        check("complete_beats_clear", {cmd_rdy, cmd}, {1'b1, 16'h1234});
        release_cmd();
        check("overrun_sticky", 64'(overrun), 64'd1);

        // rx_rdy left high across the clr edge: the byte is taken only once.
        clr_cnt = 0;
        rx_rdy = 1'b1; rx_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) rx_rdy = 1'b0;
            if (clr_rx_rdy) clr_cnt++;
        end
        check("single_capture_pulses", 64'(clr_cnt), 64'd1);
        send_byte(8'h88);
        check("single_capture_cmd", 64'(cmd), 64'h7788);
        release_cmd();

        // Asynchronous reset mid-command with a queued response.
        send_byte(8'h20);
        send_resp = 1'b1; resp = 8'hA5;
        @(negedge clk);
        resp = 8'h5A;
        @(negedge clk);
        send_resp = 1'b0;
        check("busy_before_reset", 64'(resp_busy), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, resp_busy, overrun, resp_drop, timeout},
              '0);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_done = (i == 1);
            @(negedge clk);
            if (trmt || clr_rx_rdy || resp_busy) stray = 1'b1;
        end
        tx_done = 1'b0;
        check("no_stray_after_reset", 64'(stray), 64'd0);
        send_byte(8'h20);
        send_byte(8'h00);
        check("cmd_after_reset", {cmd_rdy, cmd}, {1'b1, 16'h2000});

        // Randomised traffic against the behavioural model, including a quiet window for timeouts.
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5000; c++) begin
            if (rx_rdy && m_clr) rx_rdy = 1'b0;
            rate = (c >= 1500 && c < 3200) ? 400 : 3;
            if (!rx_rdy && !m_clr && $urandom_range(0, rate) == 0) begin
                rx_rdy  = 1'b1;
                rx_data = 8'($urandom);
            end
            clr_cmd_rdy = ($urandom_range(0, 3) == 0);
            send_resp   = ($urandom_range(0, 3) == 0);
            resp        = 8'($urandom);
            tx_done     = ($urandom_range(0, 2) == 0);
            model_step();
            @(negedge clk);
            check($sformatf("rand_cycle%0d", c),
                  {clr_rx_rdy, cmd, cmd_rdy, overrun, timeout, trmt, tx_data, resp_busy, resp_drop},
                  {m_clr, m_cmd, m_rdy, m_ovr, m_to, m_trmt, m_tx, (txq.size() > 0), m_drop});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
